// File: rtl/div_int_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider (div_int).
package div_int_pkg;

  localparam int unsigned DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

  // Iteration counter must hold the value WIDTH.
  function automatic int unsigned div_cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_int_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract b, set quotient bit.
module div_int_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_next_c,
  output logic [WIDTH-1:0] quo_next_c
);

  logic [WIDTH:0] trial_c;
  logic [WIDTH:0] diff_c;

  // rem < b always holds, so trial < 2b and a borrow in bit WIDTH means trial < b.
  always_comb begin
    trial_c    = {rem, quo[WIDTH-1]};
    diff_c     = trial_c - {1'b0, b};
    quo_next_c = {quo[WIDTH-2:0], ~diff_c[WIDTH]};
    rem_next_c = diff_c[WIDTH] ? trial_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
  end

endmodule

// File: rtl/div_int.sv
// Sequential restoring integer divider, one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement operation when DIV_SIGNED_EN is defined.
module div_int
  import div_int_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int unsigned CNT_W = div_cnt_w(WIDTH);

  div_state_e       state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] bq;
  logic [CNT_W-1:0] cnt;
  logic             zero;

  logic [WIDTH-1:0] rem_next_c;
  logic [WIDTH-1:0] quo_next_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH-1:0] r_src_c;
  logic [WIDTH-1:0] q_fin_c;
  logic [WIDTH-1:0] r_fin_c;

  div_int_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem),
    .quo        (quo),
    .b          (bq),
    .rem_next_c (rem_next_c),
    .quo_next_c (quo_next_c)
  );

`ifdef DIV_SIGNED_EN
  logic neg_a;
  logic neg_q;

  // Divide magnitudes; restore signs at FIN. With b==0, quo still holds |a| so r recovers a.
  always_comb begin
    a_mag_c = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag_c = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    r_src_c = zero ? quo : rem;
    q_fin_c = neg_q ? (~quo + WIDTH'(1)) : quo;
    r_fin_c = neg_a ? (~r_src_c + WIDTH'(1)) : r_src_c;
  end
`else
  always_comb begin
    a_mag_c = a;
    b_mag_c = b;
    r_src_c = zero ? quo : rem;
    q_fin_c = quo;
    r_fin_c = r_src_c;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      bq       <= '0;
      cnt      <= '0;
      zero     <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_a    <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            bq    <= b_mag_c;
            quo   <= a_mag_c;
            rem   <= '0;
            cnt   <= '0;
            zero  <= (b == '0);
            busy  <= 1'b1;
            state <= (b == '0) ? ST_FIN : ST_RUN;
`ifdef DIV_SIGNED_EN
            neg_a <= a[WIDTH-1];
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          rem <= rem_next_c;
          quo <= quo_next_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIN;
        end
        ST_FIN: begin
          q        <= zero ? '1 : q_fin_c;
          r        <= r_fin_c;
          div_zero <= zero;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_int.sv
// Self-checking bench for div_int: directed cases plus randomized operands against a reference model.
module tb_div_int;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_zero;

  int n_checks;
  int n_fail;

  div_int #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result from plain arithmetic on the operands.
  task automatic ref_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] eq, output logic [W-1:0] er, output logic ez);
    logic [W-1:0] min_v;
    min_v = '0;
    min_v[W-1] = 1'b1;
    ez = 1'b0;
    if (bv == '0) begin
      eq = '1;
      er = av;
      ez = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (av == min_v && bv == '1) begin
        eq = min_v;
        er = '0;
      end else begin
        eq = W'($signed(av) / $signed(bv));
        er = W'($signed(av) % $signed(bv));
      end
`else
      eq = av / bv;
      er = av % bv;
`endif
    end
  endtask

  // Wait for done with a cycle budget; returns edges elapsed (or 200 on timeout).
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check({tag, "_timeout"}, 64'(done), 64'd1);
  endtask

  // Entered at #1 after an edge with busy==0; issues one operation and checks the result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           n;
    ref_div(av, bv, eq, er, ez);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(tag, n);
    check({tag, "_lat"}, 64'(n), (bv == '0) ? 64'd1 : 64'(W + 1));
    check({tag, "_q"}, 64'(q), 64'(eq));
    check({tag, "_r"}, 64'(r), 64'(er));
    check({tag, "_dz"}, 64'(div_zero), 64'(ez));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q", 64'(q), 64'd0);
    check("rst_r", 64'(r), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef DIV_SIGNED_EN
    run_op(W'(-7), W'(2), "s_m7_2");
    run_op(W'(7), W'(-2), "s_7_m2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, "s_ovf");
    run_op(W'(-1234), W'(0), "s_dz");
`else
    run_op(W'(100), W'(7), "d100_7");
    run_op(32'hFFFF_FFFF, W'(1), "dmax_1");
    run_op(W'(5), W'(9), "d5_9");
    run_op(W'(1234), W'(0), "d1234_0");
`endif

    // start held high through busy: one result, then immediate back-to-back accept.
    start = 1'b1;
    a     = W'(20);
    b     = W'(3);
    @(posedge clk);
    #1;
    wait_done("hold", n);
    check("hold_lat", 64'(n), 64'(W + 1));
    check("hold_q", 64'(q), 64'd6);
    check("hold_r", 64'(r), 64'd2);
    a = W'(1000);
    b = W'(33);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_qhold", 64'(q), 64'd6);
    check("b2b_rhold", 64'(r), 64'd2);
    wait_done("b2b", n);
    check("b2b_lat", 64'(n), 64'(W + 1));
    check("b2b_q", 64'(q), 64'd30);
    check("b2b_r", 64'(r), 64'd10);
    pulses = 0;
    for (int i = 0; i < int'(W) + 3; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("idle_pulses", 64'(pulses), 64'd0);
    check("idle_qhold", 64'(q), 64'd30);
    check("idle_rhold", 64'(r), 64'd10);

    // Reset 10 cycles into RUN aborts without a done pulse.
    start = 1'b1;
    a     = W'(99999);
    b     = W'(17);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_q", 64'(q), 64'd0);
    check("abort_r", 64'(r), 64'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < int'(W) + 3; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_pulses", 64'(pulses), 64'd0);
    run_op(W'(99999), W'(17), "post_abort");

    // Randomized operands, biased toward small and zero divisors.
    for (int k = 0; k < 30; k++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = ra >> $urandom_range(0, W - 1);
        default: rb = W'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 255));
      run_op(ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
